alu_mb_seq: RTL
===============

// Module: alu_mb_seq
// PURPOSE
//  Multi-byte ALU sequencer. Accepts one NBYTES-wide operation over a valid/ready request port and
//  executes it LSB-byte-first on one instance of the core 8-bit alu, one byte per clock.
//  Chains carry/borrow between bytes and accumulates the zero flag.
//  Returns the wide result on a valid/ready response port.
//  Sits between the core control unit and the 8-bit alu for 16/32-bit arithmetic and logic ops.
// PARAMETERS
//  NBYTES   4   operand width in bytes (>=1); W = 8*NBYTES
// PORTS
//  CLK_ip        in   1   single clock; all state updates on rising edge
//  RST_ip        in   1   synchronous, active-high reset
//  REQ_VALID_ip  in   1   request valid
//  REQ_READY_op  out  1   request ready (high only in IDLE)
//  SEL_ip        in   5   opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT(A), 5 XOR, 6 BS, 7 BC, 8 PASSA, 9 PASSB
//  A_ip, B_ip    in   W   operands
//  CF_ip         in   1   carry-in (ADD) / borrow-in (SUB); ignored for other ops
//  RES_VALID_op  out  1   result valid
//  RES_READY_ip  in   1   result accepted
//  O_op          out  W   result
//  CF_op         out  1   carry-out (ADD) / borrow-out (SUB); 0 otherwise
//  ZF_op         out  1   1 when O_op == 0
//  BUSY_op       out  1   high in RUN or DONE
// BEHAVIOUR
//  Reset: state=IDLE. REQ_READY_op=1. RES_VALID_op=0, O_op=0, CF_op=0, ZF_op=0, BUSY_op=0.
//    Byte index=0. Reset applies in any state and discards any in-flight op.
//  FSM: IDLE -> RUN on REQ_VALID&REQ_READY; RUN -> DONE after byte NBYTES-1; DONE -> IDLE on RES_READY_ip.
//  Accept edge: latch A, B, SEL. Set byte index=0. Set chain carry: ADD = CF_ip, SUB = ~CF_ip, others = 0.
//    Set zf_acc=1.
//  RUN, byte k (k=0..NBYTES-1):
//    - Drive the alu with A[8k+:8], plus an operand byte, SEL and carry chosen per opcode:
//        ADD: B[8k+:8], SEL 0, carry = chain.
//        SUB: ~B[8k+:8], SEL 0, carry = chain (two's-complement; result = A - B - CF_ip).
//        Opcodes 2..9: B[8k+:8], SEL unchanged, carry 0.
//    - Register the alu output into O[8k+:8].
//    - chain <= alu CF_op.
//    - zf_acc <= zf_acc & alu ZF_op.
//  Illegal opcode (>=10): alu returns 0 for each byte, giving O=0, ZF=1, CF=0. No error flag.
//  Entering DONE:
//    - CF_op = chain for ADD, ~chain for SUB, 0 otherwise.
//    - ZF_op = zf_acc.
//    - RES_VALID_op=1.
//  Latency: RES_VALID_op rises NBYTES edges after the accepting edge.
//    Minimum issue interval is NBYTES+2 cycles.
//  DONE with RES_READY_ip=0: O_op, CF_op, ZF_op and RES_VALID_op held stable. REQ_READY_op stays 0.
//  In any non-IDLE state, REQ_VALID_ip is ignored (no queuing). Operands are not sampled after acceptance.
//  O_op/CF_op/ZF_op hold the last result after the DONE->IDLE handshake, until the next DONE.
//  NBYTES=1 is legal: single RUN cycle.
//  Simultaneous RES_READY and REQ_VALID in DONE: return to IDLE only; the request is taken next cycle.
// STRUCTURE
//  Shared package trsq8_alu_pkg:
//    - opcode localparams ALU_ADD..ALU_PASSB (5-bit)
//    - FSM state encodings ST_IDLE/ST_RUN/ST_DONE
//  Sub-module: one instance of the core 8-bit alu. No other hierarchy.
//  Byte index counter: $clog2(NBYTES)+1 bits.
// TESTING (NBYTES=4)
//  1. ADD A=0x0000FFFF B=0x00000001 CF=0 -> O=0x00010000, CF=0, ZF=0; RES_VALID 4 edges after accept.
//  2. SUB A=0x00000000 B=0x00000001 CF=0 -> O=0xFFFFFFFF, CF=1, ZF=0.
//     SUB A=5 B=3 CF=1 -> O=1, CF=0.
//  3. ADD A=0xFFFFFFFF B=0 CF=1 -> O=0, CF=1, ZF=1.
//     XOR A=B=0x12345678 -> O=0, ZF=1, CF=0.
//  4. Backpressure: hold RES_READY=0 for 5 cycles while pulsing REQ_VALID
//     -> outputs stable, REQ_READY=0, no second op accepted.
//  5. Assert RST_ip after byte 1 of RUN -> next cycle IDLE, REQ_READY=1, RES_VALID=0, O=0, BUSY=0.
//  6. SEL=5'b11111 -> O=0, ZF=1, CF=0.
//     Back-to-back ADDs with RES_READY=1 -> second accept exactly 6 cycles after first.

Source files
------------

// File: rtl/trsq8_alu_pkg.sv
// Shared definitions for the multi-byte ALU sequencer and its 8-bit core ALU:
// opcode encodings, sequencer FSM states and small carry-chain helpers.
package trsq8_alu_pkg;

   localparam logic [4:0] ALU_ADD   = 5'd0;
   localparam logic [4:0] ALU_SUB   = 5'd1;
   localparam logic [4:0] ALU_AND   = 5'd2;
   localparam logic [4:0] ALU_OR    = 5'd3;
   localparam logic [4:0] ALU_NOT   = 5'd4;
   localparam logic [4:0] ALU_XOR   = 5'd5;
   localparam logic [4:0] ALU_BS    = 5'd6;
   localparam logic [4:0] ALU_BC    = 5'd7;
   localparam logic [4:0] ALU_PASSA = 5'd8;
   localparam logic [4:0] ALU_PASSB = 5'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Chain seed at accept: SUB runs as A + ~B + ~borrow_in, so the borrow is inverted.
   function automatic logic chain_seed(input logic [4:0] sel, input logic cf_in);
      logic seed;
      seed = 1'b0;
      if (sel == ALU_ADD)
         seed = cf_in;
      else if (sel == ALU_SUB)
         seed = ~cf_in;
      return seed;
   endfunction

   // Flag reported at the end of an op: the final carry of A + ~B is the inverse of the borrow.
   function automatic logic chain_result(input logic [4:0] sel, input logic chain);
      logic cf;
      cf = 1'b0;
      if (sel == ALU_ADD)
         cf = chain;
      else if (sel == ALU_SUB)
         cf = ~chain;
      return cf;
   endfunction

endpackage

// File: rtl/alu_mb_seq_alu.sv
// Core 8-bit combinational ALU. BS/BC treat B as a bit mask (set / clear the
// bits of A selected by B), so they compose byte-by-byte into wide operations.
// Illegal opcodes produce zero with carry cleared.
module alu_mb_seq_alu
   import trsq8_alu_pkg::*;
(
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic [4:0] i_sel,
   input  logic       i_cf,
   output logic [7:0] o_o,
   output logic       o_cf,
   output logic       o_zf
);

   logic [8:0] w_sum;
   logic [8:0] w_diff;

   // Byte-wide arithmetic with carry-in; SUB reports borrow in bit 8.
   always_comb begin
      w_sum  = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cf};
      w_diff = {1'b0, i_a} - {1'b0, i_b} - {8'd0, i_cf};
   end

   // Opcode decode; carry only meaningful for ADD/SUB.
   always_comb begin
      o_o  = 8'd0;
      o_cf = 1'b0;
      case (i_sel)
         ALU_ADD: begin
            o_o  = w_sum[7:0];
            o_cf = w_sum[8];
         end
         ALU_SUB: begin
            o_o  = w_diff[7:0];
            o_cf = w_diff[8];
         end
         ALU_AND:   o_o = i_a & i_b;
         ALU_OR:    o_o = i_a | i_b;
         ALU_NOT:   o_o = ~i_a;
         ALU_XOR:   o_o = i_a ^ i_b;
         ALU_BS:    o_o = i_a | i_b;
         ALU_BC:    o_o = i_a & ~i_b;
         ALU_PASSA: o_o = i_a;
         ALU_PASSB: o_o = i_b;
         default: begin
            o_o  = 8'd0;
            o_cf = 1'b0;
         end
      endcase
      o_zf = (o_o == 8'd0);
   end

endmodule

// File: rtl/alu_mb_seq.sv
// Multi-byte ALU sequencer: accepts one wide op over valid/ready, runs it
// LSB byte first through a single 8-bit ALU (one byte per clock), chains the
// carry/borrow, accumulates the zero flag and returns the result over
// valid/ready. Output result/flags hold until the next op completes.
module alu_mb_seq
   import trsq8_alu_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                  CLK_ip,
   input  logic                  RST_ip,
   input  logic                  REQ_VALID_ip,
   output logic                  REQ_READY_op,
   input  logic [4:0]            SEL_ip,
   input  logic [8*NBYTES-1:0]   A_ip,
   input  logic [8*NBYTES-1:0]   B_ip,
   input  logic                  CF_ip,
   output logic                  RES_VALID_op,
   input  logic                  RES_READY_ip,
   output logic [8*NBYTES-1:0]   O_op,
   output logic                  CF_op,
   output logic                  ZF_op,
   output logic                  BUSY_op
);

   localparam int W     = 8 * NBYTES;
   localparam int IDX_W = $clog2(NBYTES) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   // Control state
   state_t           r_state;
   logic             r_req_ready;
   logic             r_res_valid;
   logic             r_busy;
   logic [IDX_W-1:0] r_idx;

   // Latched operation and working registers
   logic [4:0]       r_sel;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic [W-1:0]     r_acc;
   logic             r_chain;
   logic             r_zf_acc;

   // Presented result
   logic [W-1:0]     r_o;
   logic             r_cf;
   logic             r_zf;

   // Byte lane and ALU hookup
   logic [7:0]       w_a_byte;
   logic [7:0]       w_b_byte;
   logic [7:0]       w_alu_b;
   logic [4:0]       w_alu_sel;
   logic             w_alu_ci;
   logic             w_is_arith;
   logic [7:0]       w_alu_o;
   logic             w_alu_cf;
   logic             w_alu_zf;
   logic [W-1:0]     w_acc_next;
   logic             w_accept;

   assign w_accept = (r_state == ST_IDLE) && REQ_VALID_ip;

   // Select the operand bytes for the current byte index.
   always_comb begin
      w_a_byte = 8'd0;
      w_b_byte = 8'd0;
      for (int k = 0; k < NBYTES; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_a_byte = r_a[8*k +: 8];
            w_b_byte = r_b[8*k +: 8];
         end
      end
   end

   // SUB is executed as ADD of the inverted B byte; logic ops get no carry.
   always_comb begin
      w_is_arith = (r_sel == ALU_ADD) || (r_sel == ALU_SUB);
      w_alu_sel  = w_is_arith ? ALU_ADD : r_sel;
      w_alu_b    = (r_sel == ALU_SUB) ? ~w_b_byte : w_b_byte;
      w_alu_ci   = w_is_arith ? r_chain : 1'b0;
   end

   alu_mb_seq_alu u_alu (
      .i_a   (w_a_byte),
      .i_b   (w_alu_b),
      .i_sel (w_alu_sel),
      .i_cf  (w_alu_ci),
      .o_o   (w_alu_o),
      .o_cf  (w_alu_cf),
      .o_zf  (w_alu_zf)
   );

   // Merge the current ALU byte into the working result.
   always_comb begin
      w_acc_next = r_acc;
      for (int k = 0; k < NBYTES; k++) begin
         if (r_idx == IDX_W'(k))
            w_acc_next[8*k +: 8] = w_alu_o;
      end
   end

   // Sequencer FSM: IDLE -> RUN (NBYTES cycles) -> DONE -> IDLE on result accept.
   always_ff @(posedge CLK_ip) begin
      if (RST_ip) begin
         r_state     <= ST_IDLE;
         r_req_ready <= 1'b1;
         r_res_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_idx       <= '0;
         r_o         <= '0;
         r_cf        <= 1'b0;
         r_zf        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (REQ_VALID_ip) begin
                  r_state     <= ST_RUN;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_idx       <= '0;
               end
            end
            ST_RUN: begin
               r_idx <= r_idx + 1'b1;
               if (r_idx == LAST_IDX) begin
                  r_state     <= ST_DONE;
                  r_res_valid <= 1'b1;
                  r_o         <= w_acc_next;
                  r_cf        <= chain_result(r_sel, w_alu_cf);
                  r_zf        <= r_zf_acc & w_alu_zf;
               end
            end
            ST_DONE: begin
               if (RES_READY_ip) begin
                  r_state     <= ST_IDLE;
                  r_res_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
               r_res_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   // Datapath: latch the op on accept, then accumulate one byte per RUN cycle.
   always_ff @(posedge CLK_ip) begin
      if (w_accept) begin
         r_a      <= A_ip;
         r_b      <= B_ip;
         r_sel    <= SEL_ip;
         r_chain  <= chain_seed(SEL_ip, CF_ip);
         r_zf_acc <= 1'b1;
         r_acc    <= '0;
      end else if (r_state == ST_RUN) begin
         r_acc    <= w_acc_next;
         r_chain  <= w_alu_cf;
         r_zf_acc <= r_zf_acc & w_alu_zf;
      end
   end

   assign REQ_READY_op = r_req_ready;
   assign RES_VALID_op = r_res_valid;
   assign BUSY_op      = r_busy;
   assign O_op         = r_o;
   assign CF_op        = r_cf;
   assign ZF_op        = r_zf;

endmodule
